// File: rtl/sgbm_pkg.sv
// Shared SGBM definitions: cost widths, bus packing, minimum-tree latency
// and the pixel-pacing state encoding used by the path-cost aggregation blocks.
package sgbm_pkg;

  localparam int PIXEL_WIDTH  = 8;
  localparam int DISP_RANGE   = 108;
  localparam int COST_BUS_W   = DISP_RANGE * PIXEL_WIDTH;  // 864
  localparam int MIN_TREE_LAT = 8;

  // Candidate and sum widths for the per-disparity update
  localparam int CAND_W = 10;
  localparam int SUM_W  = 11;

  // Candidate value for a neighbour that lies outside the disparity range
  localparam logic [CAND_W-1:0] CAND_MAX = 10'h3FF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/path_cost_cell.sv
// One disparity of the SGBM path-cost update:
//   L = sat8( C + min(Lp, Lp_lo+P1, Lp_hi+P1, m+P2) - m ), or L = C at row start.
// HAS_LO / HAS_HI = 0 marks an edge cell whose missing neighbour is forced
// to the 0x3FF candidate so it never wins the minimum.
module path_cost_cell
  import sgbm_pkg::*;
#(
  parameter int P1     = 10,
  parameter int P2     = 120,
  parameter bit HAS_LO = 1'b1,
  parameter bit HAS_HI = 1'b1
) (
  input  logic [PIXEL_WIDTH-1:0] c,
  input  logic [PIXEL_WIDTH-1:0] lp,
  input  logic [PIXEL_WIDTH-1:0] lp_lo,
  input  logic [PIXEL_WIDTH-1:0] lp_hi,
  input  logic [PIXEL_WIDTH-1:0] m,
  input  logic                   row_start,
  output logic [PIXEL_WIDTH-1:0] l
);

  logic [CAND_W-1:0] cand_same;
  logic [CAND_W-1:0] cand_lo;
  logic [CAND_W-1:0] cand_hi;
  logic [CAND_W-1:0] cand_big;
  logic [CAND_W-1:0] min_a;
  logic [CAND_W-1:0] min_b;
  logic [CAND_W-1:0] best;
  logic [SUM_W-1:0]  sum;

  // Four-way minimum of the candidates, then add cost, remove m and saturate
  always_comb begin
    cand_same = CAND_W'(lp);
    cand_lo   = HAS_LO ? (CAND_W'(lp_lo) + CAND_W'(P1)) : CAND_MAX;
    cand_hi   = HAS_HI ? (CAND_W'(lp_hi) + CAND_W'(P1)) : CAND_MAX;
    cand_big  = CAND_W'(m) + CAND_W'(P2);

    min_a = (cand_same < cand_lo) ? cand_same : cand_lo;
    min_b = (cand_hi < cand_big) ? cand_hi : cand_big;
    best  = (min_a < min_b) ? min_a : min_b;

    // Every candidate is >= m, so the subtraction cannot go negative
    sum = SUM_W'(c) + SUM_W'(best) - SUM_W'(m);

    if (row_start) begin
      l = c;
    end else if (sum > SUM_W'(8'hFF)) begin
      l = 8'hFF;
    end else begin
      l = sum[PIXEL_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/path_cost_update.sv
// SGBM single-path (left-to-right) aggregated cost update over all
// disparities. Accepts one pixel, registers L into aggr_out, then waits out
// the downstream minimum-tree latency before accepting the next pixel so that
// min_aggr (fed back from min_aggr_cost) is min(aggr_out) when next used.
// Optional build macro AUTO_ROW_START_EN: row start comes from an internal
// column counter (0..IMG_WIDTH-1) instead of the row_start port.
module path_cost_update
  import sgbm_pkg::*;
#(
  parameter int P1 = 10,
  parameter int P2 = 120
`ifdef AUTO_ROW_START_EN
  ,
  parameter int IMG_WIDTH = 640
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cost_valid,
  output logic                   cost_ready,
  input  logic [COST_BUS_W-1:0]  cost_in,
  input  logic                   row_start,
  input  logic [PIXEL_WIDTH-1:0] min_aggr,
  output logic                   aggr_valid,
  output logic [COST_BUS_W-1:0]  aggr_out
);

  state_t                 state_q, state_d;
  logic [2:0]             wait_cnt_q, wait_cnt_d;
  logic                   primed_q, primed_d;
  logic                   aggr_valid_q, aggr_valid_d;
  logic [COST_BUS_W-1:0]  aggr_out_q, aggr_out_d;
  logic [COST_BUS_W-1:0]  l_vec;
  logic                   row_start_eff;
  logic                   transfer;

`ifdef AUTO_ROW_START_EN
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  logic [COL_W-1:0] col_q, col_d;

  // Column counter decides row start; the row_start port is not used
  always_comb begin
    row_start_eff = (col_q == '0) || !primed_q;
    col_d         = col_q;
    if (transfer) begin
      col_d = (col_q == COL_W'(IMG_WIDTH - 1)) ? '0 : col_q + 1'b1;
    end
  end

  // Column counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end
`else
  // Row start from the port, or forced until the first pixel after reset
  always_comb begin
    row_start_eff = row_start || !primed_q;
  end
`endif

  // Per-disparity update cells; edge cells drop their missing neighbour
  genvar gi;
  generate
    for (gi = 0; gi < DISP_RANGE; gi++) begin : g_cell
      localparam bit HAS_LO = (gi > 0);
      localparam bit HAS_HI = (gi < DISP_RANGE - 1);
      localparam int LO_IDX = HAS_LO ? gi - 1 : gi;
      localparam int HI_IDX = HAS_HI ? gi + 1 : gi;

      path_cost_cell #(
        .P1     (P1),
        .P2     (P2),
        .HAS_LO (HAS_LO),
        .HAS_HI (HAS_HI)
      ) u_cell (
        .c         (cost_in[gi*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .lp        (aggr_out_q[gi*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .lp_lo     (HAS_LO ? aggr_out_q[LO_IDX*PIXEL_WIDTH +: PIXEL_WIDTH] : 8'hFF),
        .lp_hi     (HAS_HI ? aggr_out_q[HI_IDX*PIXEL_WIDTH +: PIXEL_WIDTH] : 8'hFF),
        .m         (min_aggr),
        .row_start (row_start_eff),
        .l         (l_vec[gi*PIXEL_WIDTH +: PIXEL_WIDTH])
      );
    end
  endgenerate

  // Pacing FSM: accept in IDLE, then hold off for the min-tree latency
  always_comb begin
    cost_ready   = (state_q == IDLE) && !rst;
    transfer     = cost_valid && cost_ready;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    primed_d     = primed_q;
    aggr_valid_d = 1'b0;
    aggr_out_d   = aggr_out_q;

    case (state_q)
      IDLE: begin
        if (transfer) begin
          aggr_out_d   = l_vec;
          aggr_valid_d = 1'b1;
          primed_d     = 1'b1;
          wait_cnt_d   = '0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 3'(MIN_TREE_LAT - 1)) begin
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset wins over a simultaneous transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      primed_q     <= 1'b0;
      aggr_valid_q <= 1'b0;
      aggr_out_q   <= '1;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      primed_q     <= primed_d;
      aggr_valid_q <= aggr_valid_d;
      aggr_out_q   <= aggr_out_d;
    end
  end

  assign aggr_valid = aggr_valid_q;
  assign aggr_out   = aggr_out_q;

endmodule

// File: tb/tb_path_cost_update.sv
// Directed bench for path_cost_update. A small model of min_aggr_cost
// (8-stage delayed minimum of aggr_out, reset to 0xFF) closes the loop;
// min_force lets a step drive an arbitrary min_aggr value.
module tb_path_cost_update;

  localparam int DR = 108;
  localparam int BW = DR * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cost_valid;
  logic          cost_ready;
  logic [BW-1:0] cost_in;
  logic          row_start;
  logic [7:0]    min_aggr;
  logic          aggr_valid;
  logic [BW-1:0] aggr_out;

  logic          min_force;
  logic [7:0]    min_force_val;
  logic [7:0]    cur_min;
  logic [7:0]    pipe_q [8];

  int checks = 0;
  int errors = 0;

  int low_cycles, extra_pulses, cyc, npulse, p0, p1, p2;
  logic [BW-1:0] exp_vec;

  always #5 clk = ~clk;

`ifdef AUTO_ROW_START_EN
  path_cost_update #(.P1(10), .P2(120), .IMG_WIDTH(4)) dut (
`else
  path_cost_update #(.P1(10), .P2(120)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .cost_valid (cost_valid),
    .cost_ready (cost_ready),
    .cost_in    (cost_in),
    .row_start  (row_start),
    .min_aggr   (min_aggr),
    .aggr_valid (aggr_valid),
    .aggr_out   (aggr_out)
  );

  // Model of min_aggr_cost: minimum of aggr_out, 8 registered stages
  always_comb begin
    cur_min = 8'hFF;
    for (int d = 0; d < DR; d++) begin
      if (aggr_out[d*8 +: 8] < cur_min) cur_min = aggr_out[d*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pipe_q[i] <= 8'hFF;
    end else begin
      pipe_q[0] <= cur_min;
      for (int i = 1; i < 8; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign min_aggr = min_force ? min_force_val : pipe_q[7];

  function automatic logic [BW-1:0] fill(input logic [7:0] v);
    logic [BW-1:0] r;
    for (int d = 0; d < DR; d++) r[d*8 +: 8] = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    int fd;
    checks++;
    assert (obs === exp) else begin
      errors++;
      fd = 0;
      for (int d = DR - 1; d >= 0; d--) begin
        if (obs[d*8 +: 8] !== exp[d*8 +: 8]) fd = d;
      end
      $error("FAIL %s byte=%0d observed=%h expected=%h", tag, fd, obs[fd*8 +: 8], exp[fd*8 +: 8]);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input logic [BW-1:0] c, input logic rs);
    int n;
    n = 0;
    while (!cost_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", BW'(cost_ready), BW'(1'b1));
    cost_in    = c;
    row_start  = rs;
    cost_valid = 1'b1;
    @(posedge clk);
    #1;
    cost_valid = 1'b0;
    row_start  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    cost_valid    = 1'b0;
    cost_in       = '0;
    row_start     = 1'b0;
    min_force     = 1'b0;
    min_force_val = 8'h00;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", BW'(cost_ready), BW'(1'b0));
    chk("rst_valid", BW'(aggr_valid), BW'(1'b0));
    chk("rst_aggr_out", aggr_out, fill(8'hFF));
    rst = 1'b0;
    #1;
    chk("ready_after_rst", BW'(cost_ready), BW'(1'b1));

`ifdef AUTO_ROW_START_EN
    // Column counter with IMG_WIDTH=4, m forced to 0, C all 9:
    // columns 0,1,2,3 give 9,18,27,36, then the row restarts at 9
    min_force     = 1'b1;
    min_force_val = 8'h00;
    for (int k = 0; k < 9; k++) begin
      send(fill(8'd9), 1'b0);
      exp_vec = fill(8'(9 * ((k % 4) + 1)));
      chk("auto_row", aggr_out, exp_vec);
    end
    min_force = 1'b0;
`else
    // First pixel after reset is a row start even with row_start=0
    send(fill(8'd5), 1'b0);
    chk("p1_valid", BW'(aggr_valid), BW'(1'b1));
    chk("p1_aggr", aggr_out, fill(8'd5));
    low_cycles   = 0;
    extra_pulses = 0;
    while (!cost_ready && low_cycles < 20) begin
      low_cycles++;
      @(negedge clk);
      if (aggr_valid) extra_pulses++;
    end
    chk("p1_ready_low_cycles", BW'(low_cycles), BW'(8));
    chk("p1_single_pulse", BW'(extra_pulses), BW'(0));

    // Second pixel: min(5,15,15,125)=5, 5+5-5=5
    send(fill(8'd5), 1'b0);
    chk("p2_aggr", aggr_out, fill(8'd5));

    // Prior L: d=50 at 0, rest 200
    exp_vec = fill(8'd200);
    exp_vec[50*8 +: 8] = 8'd0;
    send(exp_vec, 1'b1);
    chk("prior_pattern", aggr_out, exp_vec);
    send(fill(8'd0), 1'b0);
    exp_vec = fill(8'd120);
    exp_vec[49*8 +: 8] = 8'd10;
    exp_vec[50*8 +: 8] = 8'd0;
    exp_vec[51*8 +: 8] = 8'd10;
    chk("jump_vec", aggr_out, exp_vec);
    chk("jump_d0", BW'(aggr_out[0 +: 8]), BW'(8'd120));
    chk("jump_d107", BW'(aggr_out[107*8 +: 8]), BW'(8'd120));

    // Alternating prior L (even 40, odd 100), m=40, C=7:
    // even -> 7+40-40=7, odd -> 7+min(100,50,50,160)-40=17
    for (int d = 0; d < DR; d++) exp_vec[d*8 +: 8] = (d % 2 == 0) ? 8'd40 : 8'd100;
    send(exp_vec, 1'b1);
    send(fill(8'd7), 1'b0);
    for (int d = 0; d < DR; d++) exp_vec[d*8 +: 8] = (d % 2 == 0) ? 8'd7 : 8'd17;
    chk("alt_vec", aggr_out, exp_vec);

    // Saturation with m=0xFF, then with m forced to 0 (255+120 -> 0xFF)
    send(fill(8'hFF), 1'b1);
    send(fill(8'hFF), 1'b0);
    chk("sat_m_ff", aggr_out, fill(8'hFF));
    min_force     = 1'b1;
    min_force_val = 8'h00;
    send(fill(8'hFF), 1'b0);
    chk("sat_m_0", aggr_out, fill(8'hFF));
    min_force = 1'b0;

    // Continuous cost_valid: one transfer every 9 cycles
    while (!cost_ready) @(negedge clk);
    cost_in    = fill(8'd5);
    row_start  = 1'b0;
    cost_valid = 1'b1;
    cyc = 0; npulse = 0; p0 = 0; p1 = 0; p2 = 0;
    while (npulse < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (aggr_valid) begin
        if (npulse == 0) p0 = cyc;
        else if (npulse == 1) p1 = cyc;
        else p2 = cyc;
        npulse++;
      end
    end
    chk("cont_pulses", BW'(npulse), BW'(3));
    chk("cont_period_a", BW'(p1 - p0), BW'(9));
    chk("cont_period_b", BW'(p2 - p1), BW'(9));

    // Reset in WAIT cycle 4 with cost_valid still high; m forced to 0 so a
    // non-row-start update (9+120) would differ from the expected L=C
    repeat (3) @(negedge clk);
    rst           = 1'b1;
    cost_in       = fill(8'd9);
    min_force     = 1'b1;
    min_force_val = 8'h00;
    @(negedge clk);
    chk("midwait_rst_ready", BW'(cost_ready), BW'(1'b0));
    chk("midwait_rst_aggr", aggr_out, fill(8'hFF));
    rst = 1'b0;
    @(posedge clk);
    #1;
    cost_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", BW'(aggr_valid), BW'(1'b1));
    chk("post_rst_row_start", aggr_out, fill(8'd9));
    min_force = 1'b0;
`endif

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
